// File: rtl/spi_word_decoder.sv
// Word FIFO plus command/burst decoder that turns SPI-assembled words into
// parameter-bank writes. Optional err_count output: define SPI_DECODER_ERR_COUNT_EN.
module spi_word_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [31:0]                 word_in,
    input  logic                        word_valid,
    output logic                        wr_valid,
    input  logic                        wr_ready,
    output logic [7:0]                  wr_addr,
    output logic [1:0]                  wr_sel,
    output logic [31:0]                 wr_data,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
`ifdef SPI_DECODER_ERR_COUNT_EN
    output logic [7:0]                  err_count,
`endif
    output logic                        err_opcode
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_LEVEL  = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, BURST_WAIT, BURST_ISSUE} state_t;

    logic [31:0]   mem_reg [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          fifo_empty, fifo_full, push, pop, drop, decode_err;
    logic [31:0]   head;

    state_t      state_reg, state_next;
    logic [7:0]  wr_addr_reg, wr_addr_next;
    logic [1:0]  wr_sel_reg, wr_sel_next;
    logic [31:0] wr_data_reg, wr_data_next;
    logic [7:0]  remaining_reg, remaining_next;
    logic [7:0]  baddr_reg, baddr_next;
    logic        overflow_reg, err_opcode_reg;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == FULL_LEVEL);
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push = word_valid && (!fifo_full || pop);
    assign drop = word_valid && !push;
    assign head = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= word_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + ONE_LEVEL;
            end else if (pop && !push) begin
                count_reg <= count_reg - ONE_LEVEL;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        wr_addr_next   = wr_addr_reg;
        wr_sel_next    = wr_sel_reg;
        wr_data_next   = wr_data_reg;
        remaining_next = remaining_reg;
        baddr_next     = baddr_reg;
        pop            = 1'b0;
        decode_err     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    case (head[31:24])
                        8'h00: begin
                        end
                        8'h01, 8'h02, 8'h03: begin
                            wr_addr_next = head[23:16];
                            wr_sel_next  = head[25:24] - 2'd1;
                            wr_data_next = {{16{head[15]}}, head[15:0]};
                            state_next   = ISSUE;
                        end
                        8'h10: begin
                            if (head[7:0] == 8'd0) begin
                                decode_err = 1'b1;
                            end else begin
                                remaining_next = head[7:0];
                                baddr_next     = head[23:16];
                                state_next     = BURST_WAIT;
                            end
                        end
                        default: decode_err = 1'b1;
                    endcase
                end
            end
            ISSUE: begin
                if (wr_ready) begin
                    state_next = IDLE;
                end
            end
            BURST_WAIT: begin
                // Burst payload words bypass the decoder entirely.
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    wr_data_next = head;
                    wr_addr_next = baddr_reg;
                    wr_sel_next  = 2'b11;
                    state_next   = BURST_ISSUE;
                end
            end
            BURST_ISSUE: begin
                if (wr_ready) begin
                    remaining_next = remaining_reg - 8'd1;
                    baddr_next     = baddr_reg + 8'd1;
                    state_next     = (remaining_reg == 8'd1) ? IDLE : BURST_WAIT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            wr_addr_reg    <= '0;
            wr_sel_reg     <= '0;
            wr_data_reg    <= '0;
            remaining_reg  <= '0;
            baddr_reg      <= '0;
            overflow_reg   <= 1'b0;
            err_opcode_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wr_addr_reg    <= wr_addr_next;
            wr_sel_reg     <= wr_sel_next;
            wr_data_reg    <= wr_data_next;
            remaining_reg  <= remaining_next;
            baddr_reg      <= baddr_next;
            overflow_reg   <= overflow_reg | drop;
            err_opcode_reg <= err_opcode_reg | decode_err;
        end
    end

`ifdef SPI_DECODER_ERR_COUNT_EN
    logic [7:0] err_count_reg;
    logic [8:0] err_sum;

    // A drop and a decode error in one cycle count as two events.
    assign err_sum = {1'b0, err_count_reg} + 9'(drop) + 9'(decode_err);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_reg <= '0;
        end else begin
            err_count_reg <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    assign err_count = err_count_reg;
`endif

    assign wr_valid   = (state_reg == ISSUE) || (state_reg == BURST_ISSUE);
    assign wr_addr    = wr_addr_reg;
    assign wr_sel     = wr_sel_reg;
    assign wr_data    = wr_data_reg;
    assign busy       = (state_reg != IDLE) || !fifo_empty;
    assign fifo_level = count_reg;
    assign overflow   = overflow_reg;
    assign err_opcode = err_opcode_reg;

endmodule

// File: tb/tb_spi_word_decoder.sv
// Self-checking bench for spi_word_decoder: vector table, directed corner
// sequences and randomized batches scored against a word-level reference model.
module tb_spi_word_decoder;
    logic        clk;
    logic        rst_n;
    logic [31:0] word_in;
    logic        word_valid;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_addr;
    logic [1:0]  wr_sel;
    logic [31:0] wr_data;
    logic        busy;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        err_opcode;
`ifdef SPI_DECODER_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    spi_word_decoder #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_in    (word_in),
        .word_valid (word_valid),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .busy       (busy),
        .fifo_level (fifo_level),
        .overflow   (overflow),
`ifdef SPI_DECODER_ERR_COUNT_EN
        .err_count  (err_count),
`endif
        .err_opcode (err_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int hs_count = 0;
    int ready_mode = 0;   // 0 fixed, 1 toggle each cycle, 2 random
    bit mon_en = 0;
    bit prev_stall = 0;
    logic [42:0] prev_out;

    // Reference model state: expected writes in order, open burst, sticky error.
    logic [41:0] exp_q[$];
    int          m_left = 0;
    logic [7:0]  m_addr = 8'd0;
    bit          m_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ready_mode == 1) wr_ready = ~wr_ready;
        else if (ready_mode == 2) wr_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic model_word(input logic [31:0] w);
        logic [7:0] op;
        op = w[31:24];
        if (m_left > 0) begin
            exp_q.push_back({m_addr, 2'b11, w});
            m_addr = m_addr + 8'd1;
            m_left--;
        end else if (op >= 8'h01 && op <= 8'h03) begin
            exp_q.push_back({w[23:16], 2'(op - 8'd1), 32'($signed(w[15:0]))});
        end else if (op == 8'h10) begin
            if (w[7:0] == 8'd0) m_err = 1;
            else begin
                m_left = int'(w[7:0]);
                m_addr = w[23:16];
            end
        end else if (op != 8'h00) begin
            m_err = 1;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        word_in = w;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        word_in = '0;
    endtask

    task automatic push_m(input logic [31:0] w);
        model_word(w);
        push_word(w);
    endtask

    task automatic do_reset();
        mon_en = 0;
        ready_mode = 0;
        rst_n = 1'b0;
        word_valid = 1'b0;
        word_in = '0;
        wr_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        m_left = 0;
        m_err = 0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < limit) begin
            tick();
            k++;
        end
        check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_wr_valid"}, 64'(wr_valid), 64'd0);
        check({name, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check({name, "_wr_sel"}, 64'(wr_sel), 64'd0);
        check({name, "_wr_data"}, 64'(wr_data), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_level"}, 64'(fifo_level), 64'd0);
        check({name, "_overflow"}, 64'(overflow), 64'd0);
        check({name, "_err"}, 64'(err_opcode), 64'd0);
`ifdef SPI_DECODER_ERR_COUNT_EN
        check({name, "_err_count"}, 64'(err_count), 64'd0);
`endif
    endtask

    // Write monitor: scores handshakes against the model and checks stall stability.
    always @(negedge clk) begin
        if (wr_valid && wr_ready) hs_count++;
        if (mon_en) begin
            if (prev_stall) check("stall_hold", 64'({wr_valid, wr_addr, wr_sel, wr_data}), 64'(prev_out));
            if (wr_valid && wr_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_write: got addr %0h sel %0h data %0h required none",
                             wr_addr, wr_sel, wr_data);
                end else begin
                    check("write", 64'({wr_addr, wr_sel, wr_data}), 64'(exp_q.pop_front()));
                end
            end
            prev_stall = wr_valid && !wr_ready;
            prev_out = {wr_valid, wr_addr, wr_sel, wr_data};
        end else begin
            prev_stall = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] word;
        bit          wr;
        logic [7:0]  addr;
        logic [1:0]  sel;
        logic [31:0] data;
        bit          err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int seen, k, hs_base, n, gap, kind;
        logic [41:0] cap;
        logic [31:0] w;
        logic [7:0] op;

        vecs[0] = '{32'h0105FFF0, 1'b1, 8'h05, 2'b00, 32'hFFFFFFF0, 1'b0};
        vecs[1] = '{32'h02AA7FFF, 1'b1, 8'hAA, 2'b01, 32'h00007FFF, 1'b0};
        vecs[2] = '{32'h03FF8000, 1'b1, 8'hFF, 2'b10, 32'hFFFF8000, 1'b0};
        vecs[3] = '{32'h00123456, 1'b0, 8'h00, 2'b00, 32'h0,        1'b0};
        vecs[4] = '{32'h7F000000, 1'b0, 8'h00, 2'b00, 32'h0,        1'b1};
        vecs[5] = '{32'h10331200, 1'b0, 8'h00, 2'b00, 32'h0,        1'b1};
        vecs[6] = '{32'h04000001, 1'b0, 8'h00, 2'b00, 32'h0,        1'b1};
        vecs[7] = '{32'hFF010203, 1'b0, 8'h00, 2'b00, 32'h0,        1'b1};

        // Reset values and single-write latency.
        do_reset();
        check_reset_outputs("reset");
        wr_ready = 1'b1;
        push_word(32'h0105FFF0);
        check("lat_c1_valid", 64'(wr_valid), 64'd0);
        check("lat_c1_level", 64'(fifo_level), 64'd1);
        check("lat_c1_busy", 64'(busy), 64'd1);
        tick();
        check("lat_c2_valid", 64'(wr_valid), 64'd1);
        check("lat_c2_write", 64'({wr_addr, wr_sel, wr_data}), 64'({8'h05, 2'b00, 32'hFFFFFFF0}));
        tick();
        check("lat_c3_valid", 64'(wr_valid), 64'd0);
        check("lat_c3_busy", 64'(busy), 64'd0);

        // Vector table: one word per reset.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            wr_ready = 1'b1;
            push_word(vecs[v].word);
            seen = 0;
            cap = '0;
            for (int j = 0; j < 5; j++) begin
                if (wr_valid) begin
                    seen++;
                    cap = {wr_addr, wr_sel, wr_data};
                end
                tick();
            end
            check($sformatf("vec%0d_writes", v), 64'(seen), 64'(vecs[v].wr));
            if (vecs[v].wr) check($sformatf("vec%0d_data", v), 64'(cap), 64'({vecs[v].addr, vecs[v].sel, vecs[v].data}));
            check($sformatf("vec%0d_err", v), 64'(err_opcode), 64'(vecs[v].err));
            check($sformatf("vec%0d_busy", v), 64'(busy), 64'd0);
        end

        // Burst across the address wrap with wr_ready toggling.
        do_reset();
        mon_en = 1;
        ready_mode = 1;
        push_m(32'h10FE0003);
        push_m(32'h0000000A);
        push_m(32'h0000000B);
        push_m(32'h0000000C);
        wait_drain("burst_wrap", 40);
        check("burst_wrap_err", 64'(err_opcode), 64'd0);

        // Overflow: six commands into a stalled depth-4 FIFO; sixth dropped.
        do_reset();
        mon_en = 1;
        hs_base = hs_count;
        for (int i = 0; i < 5; i++) push_m({8'h01, 8'(8'h10 + i), 16'(16'h0100 + i)});
        push_word(32'h01150105);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_level", 64'(fifo_level), 64'd4);
        // Release: the handshake cycle pops nothing so this word drops too; the
        // next cycle pops the head and a simultaneous push is accepted.
        wr_ready = 1'b1;
        push_word(32'h01160106);
        push_m(32'h01170107);
        check("full_pushpop_level", 64'(fifo_level), 64'd4);
        wait_drain("ovf", 40);
        check("ovf_write_count", 64'(hs_count - hs_base), 64'd6);
`ifdef SPI_DECODER_ERR_COUNT_EN
        check("ovf_err_count", 64'(err_count), 64'd2);
`endif

        // Illegal opcode and zero-length burst, then a valid threshold write.
        do_reset();
        mon_en = 1;
        wr_ready = 1'b1;
        push_m(32'h7F000000);
        check("err_not_yet", 64'(err_opcode), 64'd0);
        push_m(32'h10000000);
        check("err_sticky", 64'(err_opcode), 64'd1);
        push_m(32'h02010010);
        wait_drain("err_seq", 20);
        check("err_final", 64'(err_opcode), 64'(m_err));
`ifdef SPI_DECODER_ERR_COUNT_EN
        check("err_count", 64'(err_count), 64'd2);
`endif

        // Reset in the middle of a burst with two words still to go.
        do_reset();
        mon_en = 1;
        wr_ready = 1'b1;
        hs_base = hs_count;
        push_m(32'h10200004);
        for (int i = 0; i < 4; i++) push_m(32'hD0000000 + i);
        k = 0;
        while (hs_count - hs_base < 2 && k < 20) begin
            tick();
            k++;
        end
        check("midburst_two_writes", 64'(hs_count - hs_base), 64'd2);
        mon_en = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_outputs("midburst_reset");
        exp_q.delete();
        m_left = 0;
        m_err = 0;
        mon_en = 1;
        push_m(32'h03020001);
        wait_drain("post_reset", 20);
        check("post_reset_err", 64'(err_opcode), 64'd0);

        // Randomized batches of at most four words against the reference model.
        do_reset();
        mon_en = 1;
        ready_mode = 2;
        for (int b = 0; b < 40; b++) begin
            n = 4;
            while (n > 0) begin
                kind = $urandom_range(0, 9);
                if (kind >= 7 && n >= 2) begin
                    k = $urandom_range(1, n - 1);
                    push_m({8'h10, 8'($urandom), 8'($urandom), 8'(k)});
                    for (int i = 0; i < k; i++) push_m($urandom);
                    n = n - 1 - k;
                end else begin
                    if (kind == 0) w = {8'h00, 24'($urandom)};
                    else if (kind == 1) begin
                        do op = 8'($urandom); while (op <= 8'h03 || op == 8'h10);
                        w = {op, 24'($urandom)};
                    end else if (kind == 2) w = {8'h10, 8'($urandom), 8'($urandom), 8'h00};
                    else w = {8'($urandom_range(1, 3)), 24'($urandom)};
                    push_m(w);
                    n--;
                end
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) tick();
            end
            wait_drain($sformatf("rand%0d", b), 200);
            check($sformatf("rand%0d_err", b), 64'(err_opcode), 64'(m_err));
            check($sformatf("rand%0d_ovf", b), 64'(overflow), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
